// File: rtl/vga_timing_gen_if.sv
// Pixel/timing bundle between the scene renderer (master) and the VGA timing
// generator (slave). With VGA_TEST_PATTERN_EN defined, the bundle also carries
// pattern_sel, which selects the built-in colour-bar pattern.
interface vga_timing_gen_if #(
  parameter int COLOR_W = 4,
  parameter int XW      = 10,
  parameter int YW      = 10
);
  logic               enable;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;
`ifdef VGA_TEST_PATTERN_EN
  logic               pattern_sel;
`endif
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic               line_start;
  logic               frame_start;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [COLOR_W-1:0] R;
  logic [COLOR_W-1:0] G;
  logic [COLOR_W-1:0] B;

`ifdef VGA_TEST_PATTERN_EN
  modport master (output enable, pix_r, pix_g, pix_b, pattern_sel,
                  input  x, y, line_start, frame_start, hsync, vsync, de, R, G, B);
  modport slave  (input  enable, pix_r, pix_g, pix_b, pattern_sel,
                  output x, y, line_start, frame_start, hsync, vsync, de, R, G, B);
`else
  modport master (output enable, pix_r, pix_g, pix_b,
                  input  x, y, line_start, frame_start, hsync, vsync, de, R, G, B);
  modport slave  (input  enable, pix_r, pix_g, pix_b,
                  output x, y, line_start, frame_start, hsync, vsync, de, R, G, B);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator and pixel output stage.
// Counters give x/y and the line/frame pulses combinationally; sync, data
// enable and RGB are registered one pixel tick behind the counters.
// Optional macro VGA_TEST_PATTERN_EN adds an 8-bar colour pattern selected by
// pattern_sel (H_ACTIVE must be a multiple of 8).
module vga_timing_gen #(
  parameter int COLOR_W   = 4,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIX_DIV   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  vga_timing_gen_if.slave  bus
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW       = $clog2(H_TOTAL);
  localparam int YW       = $clog2(V_TOTAL);
  localparam int PW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [PW-1:0]      r_presc;
  logic [XW-1:0]      r_hCnt;
  logic [YW-1:0]      r_vCnt;
  logic               r_de;
  logic               r_hsync;
  logic               r_vsync;
  logic [COLOR_W-1:0] r_R;
  logic [COLOR_W-1:0] r_G;
  logic [COLOR_W-1:0] r_B;

  logic               w_tick;
  logic               w_hLast;
  logic               w_vLast;
  logic [31:0]        w_hInt;
  logic [31:0]        w_vInt;
  logic               w_de;
  logic               w_hsAct;
  logic               w_vsAct;
  logic [COLOR_W-1:0] w_srcR;
  logic [COLOR_W-1:0] w_srcG;
  logic [COLOR_W-1:0] w_srcB;

  assign w_tick  = (r_presc == PW'(PIX_DIV - 1));
  assign w_hLast = (r_hCnt == XW'(H_TOTAL - 1));
  assign w_vLast = (r_vCnt == YW'(V_TOTAL - 1));
  assign w_hInt  = 32'(r_hCnt);
  assign w_vInt  = 32'(r_vCnt);
  assign w_de    = (w_hInt < H_ACTIVE) && (w_vInt < V_ACTIVE);
  assign w_hsAct = (w_hInt >= HS_START) && (w_hInt < HS_END);
  assign w_vsAct = (w_vInt >= VS_START) && (w_vInt < VS_END);

  // Prescaler and raster counters; enable low parks everything at frame start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_hCnt  <= '0;
      r_vCnt  <= '0;
    end else if (!bus.enable) begin
      r_presc <= '0;
      r_hCnt  <= '0;
      r_vCnt  <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      if (w_hLast) begin
        r_hCnt <= '0;
        r_vCnt <= w_vLast ? '0 : r_vCnt + 1'b1;
      end else begin
        r_hCnt <= r_hCnt + 1'b1;
      end
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [BW-1:0] r_barPix;
  logic [2:0]    r_barIdx;

  // Bar index tracks the current h_cnt: restarts each line, steps every BAR_W visible pixels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_barPix <= '0;
      r_barIdx <= '0;
    end else if (!bus.enable) begin
      r_barPix <= '0;
      r_barIdx <= '0;
    end else if (w_tick) begin
      if (w_hLast) begin
        r_barPix <= '0;
        r_barIdx <= '0;
      end else if (w_hInt < H_ACTIVE) begin
        if (r_barPix == BW'(BAR_W - 1)) begin
          r_barPix <= '0;
          r_barIdx <= r_barIdx + 1'b1;
        end else begin
          r_barPix <= r_barPix + 1'b1;
        end
      end
    end
  end

  assign w_srcR = bus.pattern_sel ? {COLOR_W{r_barIdx[0]}} : bus.pix_r;
  assign w_srcG = bus.pattern_sel ? {COLOR_W{r_barIdx[1]}} : bus.pix_g;
  assign w_srcB = bus.pattern_sel ? {COLOR_W{r_barIdx[2]}} : bus.pix_b;
`else
  assign w_srcR = bus.pix_r;
  assign w_srcG = bus.pix_g;
  assign w_srcB = bus.pix_b;
`endif

  // Output stage: sync, data enable and blanked colour registered on each pixel tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_de    <= 1'b0;
      r_hsync <= ~HSYNC_POL;
      r_vsync <= ~VSYNC_POL;
      r_R     <= '0;
      r_G     <= '0;
      r_B     <= '0;
    end else if (!bus.enable) begin
      r_de    <= 1'b0;
      r_hsync <= ~HSYNC_POL;
      r_vsync <= ~VSYNC_POL;
      r_R     <= '0;
      r_G     <= '0;
      r_B     <= '0;
    end else if (w_tick) begin
      r_de    <= w_de;
      r_hsync <= w_hsAct ? HSYNC_POL : ~HSYNC_POL;
      r_vsync <= w_vsAct ? VSYNC_POL : ~VSYNC_POL;
      r_R     <= w_de ? w_srcR : '0;
      r_G     <= w_de ? w_srcG : '0;
      r_B     <= w_de ? w_srcB : '0;
    end
  end

  assign bus.x           = r_hCnt;
  assign bus.y           = r_vCnt;
  assign bus.line_start  = bus.enable && w_tick && (r_hCnt == '0);
  assign bus.frame_start = bus.enable && w_tick && (r_hCnt == '0) && (r_vCnt == '0);
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.de          = r_de;
  assign bus.R           = r_R;
  assign bus.G           = r_G;
  assign bus.B           = r_B;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen on a small raster (H 8/2/3/1, V 4/1/2/1).
// DUT A runs PIX_DIV=1 with a pixel scoreboard; DUT B runs PIX_DIV=3;
// DUT C (only with VGA_TEST_PATTERN_EN) shows the colour bars at H_ACTIVE=16.
module tb_vga_timing_gen;
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pix_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic resetB_n = 1'b0;
  logic resetC_n = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   pushes = 0;
  int   pops = 0;
  int   vsLow = 0;
  int   lsCount = 0;
  int   fsCount = 0;
  logic bDone = 1'b0;
  logic cDone = 1'b0;
  pix_t sbQ[$];

  always #5 clk = ~clk;

  vga_timing_gen_if #(.COLOR_W(4), .XW(4), .YW(3)) ifA ();
  vga_timing_gen_if #(.COLOR_W(4), .XW(4), .YW(3)) ifB ();

  vga_timing_gen #(
    .COLOR_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_DIV(1)
  ) dutA (.clk(clk), .reset_n(reset_n), .bus(ifA.slave));

  vga_timing_gen #(
    .COLOR_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_DIV(3)
  ) dutB (.clk(clk), .reset_n(resetB_n), .bus(ifB.slave));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives count pixels on DUT A starting at raster index startN; entered at a negedge
  task automatic applyStimulus(input int startN, input int count);
    for (int k = 0; k < count; k++) begin
      int         n;
      int         px;
      int         py;
      logic [3:0] nLow;
      logic       expDe;
      pix_t       e;
      n     = startN + k;
      px    = n % 14;
      py    = (n / 14) % 8;
      nLow  = 4'(n);
      #1;
      checkOutput("x", 32'(ifA.x), px);
      checkOutput("y", 32'(ifA.y), py);
      checkOutput("line_start", 32'(ifA.line_start), 32'(px == 0));
      checkOutput("frame_start", 32'(ifA.frame_start), 32'(px == 0 && py == 0));
      if (ifA.line_start === 1'b1) lsCount++;
      if (ifA.frame_start === 1'b1) fsCount++;
      ifA.pix_r = 4'hF;
      ifA.pix_g = nLow;
      ifA.pix_b = ~nLow;
      expDe = (px < 8) && (py < 4);
      e.de = expDe;
      e.hs = !(px >= 10 && px < 13);
      e.vs = !(py >= 5 && py < 7);
      e.r  = expDe ? 4'hF : 4'h0;
      e.g  = expDe ? nLow : 4'h0;
      e.b  = expDe ? ~nLow : 4'h0;
      sbQ.push_back(e);
      pushes++;
      @(negedge clk);
    end
  endtask

  // Scoreboard monitor: every DUT A pixel tick presents the previous pixel's registered outputs
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
        pix_t e;
        pix_t a;
        e = sbQ.pop_front();
        a = {ifA.de, ifA.hsync, ifA.vsync, ifA.R, ifA.G, ifA.B};
        pops++;
        checkOutput("pixel", 32'(a), 32'(e));
        if (ifA.vsync === 1'b0) vsLow++;
      end
    end
  end

  // DUT B: PIX_DIV=3 counter pacing, line_start width and hsync period/width
  initial begin
    int lowCnt;
    int fall1;
    int fall2;
    logic prevHs;
    lowCnt = 0;
    fall1 = -1;
    fall2 = -1;
    ifB.enable = 1'b1;
    ifB.pix_r = 4'h3;
    ifB.pix_g = 4'h5;
    ifB.pix_b = 4'h9;
`ifdef VGA_TEST_PATTERN_EN
    ifB.pattern_sel = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    checkOutput("B reset hsync", 32'(ifB.hsync), 1);
    checkOutput("B reset x", 32'(ifB.x), 0);
    resetB_n = 1'b1;
    prevHs = 1'b1;
    for (int k = 0; k < 84; k++) begin
      int h;
      h = (k / 3) % 14;
      checkOutput("B x", 32'(ifB.x), h);
      checkOutput("B line_start", 32'(ifB.line_start), 32'((k % 3 == 2) && (h == 0)));
      if (ifB.hsync === 1'b0) begin
        lowCnt++;
        if (prevHs === 1'b1) begin
          if (fall1 < 0) fall1 = k;
          else if (fall2 < 0) fall2 = k;
        end
      end
      prevHs = ifB.hsync;
      @(negedge clk);
      #1;
    end
    checkOutput("B hsync low clks", lowCnt, 18);
    checkOutput("B first hsync fall", fall1, 33);
    checkOutput("B hsync period", fall2 - fall1, 42);
    bDone = 1'b1;
  end

`ifdef VGA_TEST_PATTERN_EN
  vga_timing_gen_if #(.COLOR_W(4), .XW(5), .YW(3)) ifC ();

  vga_timing_gen #(
    .COLOR_W(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_DIV(1)
  ) dutC (.clk(clk), .reset_n(resetC_n), .bus(ifC.slave));

  // DUT C: colour bars two pixels wide; sample k shows pixel k-1
  initial begin
    ifC.enable = 1'b1;
    ifC.pattern_sel = 1'b1;
    ifC.pix_r = 4'h0;
    ifC.pix_g = 4'h0;
    ifC.pix_b = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    resetC_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      int p;
      logic [11:0] rgb;
      p = k - 1;
      rgb = {ifC.R, ifC.G, ifC.B};
      if (p == 0 || p == 1) checkOutput("C bar0", 32'(rgb), 32'h000);
      if (p == 4 || p == 5) checkOutput("C bar2", 32'(rgb), 32'h0F0);
      if (p == 10 || p == 11) checkOutput("C bar5", 32'(rgb), 32'hF0F);
      if (p == 14 || p == 15) checkOutput("C bar7", 32'(rgb), 32'hFFF);
      @(negedge clk);
      #1;
    end
    cDone = 1'b1;
  end
`else
  initial cDone = 1'b1;
`endif

  // Main sequence on DUT A: reset, two full frames, async reset, enable clear
  initial begin
    ifA.enable = 1'b1;
    ifA.pix_r = 4'hF;
    ifA.pix_g = 4'h0;
    ifA.pix_b = 4'h0;
`ifdef VGA_TEST_PATTERN_EN
    ifA.pattern_sel = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset hsync", 32'(ifA.hsync), 1);
    checkOutput("reset vsync", 32'(ifA.vsync), 1);
    checkOutput("reset de", 32'(ifA.de), 0);
    checkOutput("reset rgb", 32'({ifA.R, ifA.G, ifA.B}), 0);
    checkOutput("reset x", 32'(ifA.x), 0);
    checkOutput("reset y", 32'(ifA.y), 0);
    reset_n = 1'b1;
    applyStimulus(0, 257);
    checkOutput("vsync low clks", vsLow, 56);
    checkOutput("frame_start count", fsCount, 3);
    checkOutput("line_start count", lsCount, 19);

    #1;
    checkOutput("pre-reset x", 32'(ifA.x), 5);
    checkOutput("pre-reset y", 32'(ifA.y), 2);
    checkOutput("pre-reset de", 32'(ifA.de), 1);
    checkOutput("pre-reset R", 32'(ifA.R), 32'hF);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async de", 32'(ifA.de), 0);
    checkOutput("async R", 32'(ifA.R), 0);
    checkOutput("async x", 32'(ifA.x), 0);
    checkOutput("async y", 32'(ifA.y), 0);
    checkOutput("async hsync", 32'(ifA.hsync), 1);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(0, 33);

    #1;
    ifA.enable = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("disable x", 32'(ifA.x), 0);
    checkOutput("disable y", 32'(ifA.y), 0);
    checkOutput("disable de", 32'(ifA.de), 0);
    checkOutput("disable R", 32'(ifA.R), 0);
    checkOutput("disable vsync", 32'(ifA.vsync), 1);
    checkOutput("disable frame_start", 32'(ifA.frame_start), 0);
    checkOutput("disable line_start", 32'(ifA.line_start), 0);
    ifA.enable = 1'b1;
    applyStimulus(0, 30);

    @(negedge clk);
    checkOutput("scoreboard drained", 32'(sbQ.size()), 0);
    checkOutput("scoreboard pops", pops, pushes);
    for (int i = 0; i < 200 && !(bDone && cDone); i++) @(negedge clk);
    checkOutput("side benches done", 32'(bDone && cDone), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
